// File: rtl/axi_pkg.sv
// Shared AXI encodings and the write-responder FSM state type.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_wr_responder_if.sv
// AXI write channels (AW/W/B) between a master and the write responder.
// Handshake rule on every channel: a beat transfers on the rising clk edge
// where valid and ready are both high; the source holds its payload stable
// and keeps valid high until that edge, and ready never waits on valid.
// dbg_state mirrors the responder FSM for checkers.
interface axi_wr_responder_if #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ID_WIDTH-1:0]   s_axi_awid;
  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic [7:0]            s_axi_awlen;
  logic [2:0]            s_axi_awsize;
  logic [1:0]            s_axi_awburst;
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;
  logic [DATA_WIDTH-1:0] s_axi_wdata;
  logic [STRB_WIDTH-1:0] s_axi_wstrb;
  logic                  s_axi_wlast;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic [ID_WIDTH-1:0]   s_axi_bid;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;
  axi_pkg::state_t       dbg_state;

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
           s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
           s_axi_bready,
    input  s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
           dbg_state
  );

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
           s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
           s_axi_bready,
    output s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
           dbg_state
  );
endinterface

// File: rtl/axi_burst_addr_next.sv
// Address of the next beat of an AXI burst (FIXED / INCR / WRAP).
module axi_burst_addr_next
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  // Extended width so the wrap window size never overflows for small ADDR_WIDTH.
  localparam int EW = ADDR_WIDTH + 16;

  logic [EW-1:0] step;
  logic [EW-1:0] wrap_mask;
  logic [EW-1:0] incr_addr;

  // Step by one beat; WRAP keeps the bits above the aligned window fixed.
  always_comb begin
    step      = EW'(1) << size;
    wrap_mask = ((EW'(len) + EW'(1)) << size) - EW'(1);
    incr_addr = EW'(addr) + step;
    case (burst)
      BURST_INCR: next_addr = incr_addr[ADDR_WIDTH-1:0];
      BURST_WRAP: next_addr = ADDR_WIDTH'((EW'(addr) & ~wrap_mask) | (incr_addr & wrap_mask));
      default:    next_addr = addr;
    endcase
  end
endmodule

// File: rtl/axi_wr_responder.sv
// Single-outstanding AXI write responder driving a word-wide memory write port.
module axi_wr_responder
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int ID_WIDTH       = 8,
  parameter int MEM_ADDR_WIDTH = ADDR_WIDTH - $clog2(STRB_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  axi_wr_responder_if.slave         s_axi,
  output logic [MEM_ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0]     mem_wr_data,
  output logic [STRB_WIDTH-1:0]     mem_wr_strb,
  output logic                      mem_wr_en
);
  localparam int ADDR_LSB = $clog2(STRB_WIDTH);

  state_t                    state_q, state_d;
  logic [ID_WIDTH-1:0]       id_q, id_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [2:0]                size_q, size_d;
  logic [1:0]                burst_q, burst_d;
  logic [7:0]                beat_q, beat_d;
  // aw_err blocks memory writes; wlast_err only colours the response.
  logic                      aw_err_q, aw_err_d;
  logic                      wlast_err_q, wlast_err_d;
  logic                      mem_wr_en_q, mem_wr_en_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_wr_addr_q, mem_wr_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wr_data_q, mem_wr_data_d;
  logic [STRB_WIDTH-1:0]     mem_wr_strb_q, mem_wr_strb_d;
  logic [ADDR_WIDTH-1:0]     next_addr;
  logic                      last_beat;

  axi_burst_addr_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_next (
    .addr      (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  assign last_beat = (beat_q == len_q);

  // Channel handshakes are pure decodes of the current state.
  always_comb begin
    s_axi.s_axi_awready = (state_q == ST_IDLE) && !rst;
    s_axi.s_axi_wready  = (state_q == ST_BURST);
    s_axi.s_axi_bvalid  = (state_q == ST_RESP);
    s_axi.s_axi_bid     = id_q;
    s_axi.s_axi_bresp   = (aw_err_q || wlast_err_q) ? RESP_SLVERR : RESP_OKAY;
    s_axi.dbg_state     = state_q;
  end

  // Next-state, burst bookkeeping and memory-write registration.
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    addr_d        = addr_q;
    len_d         = len_q;
    size_d        = size_q;
    burst_d       = burst_q;
    beat_d        = beat_q;
    aw_err_d      = aw_err_q;
    wlast_err_d   = wlast_err_q;
    mem_wr_en_d   = 1'b0;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_strb_d = mem_wr_strb_q;
    case (state_q)
      ST_IDLE: begin
        if (s_axi.s_axi_awvalid) begin
          id_d        = s_axi.s_axi_awid;
          addr_d      = s_axi.s_axi_awaddr;
          len_d       = s_axi.s_axi_awlen;
          size_d      = s_axi.s_axi_awsize;
          burst_d     = s_axi.s_axi_awburst;
          beat_d      = 8'd0;
          wlast_err_d = 1'b0;
          aw_err_d    = (s_axi.s_axi_awburst == BURST_RSVD)
                     || (int'(s_axi.s_axi_awsize) > ADDR_LSB)
                     || ((s_axi.s_axi_awburst == BURST_WRAP) && !wrap_len_ok(s_axi.s_axi_awlen));
          state_d     = ST_BURST;
        end
      end
      ST_BURST: begin
        if (s_axi.s_axi_wvalid) begin
          beat_d = beat_q + 8'd1;
          addr_d = next_addr;
          if (!aw_err_q) begin
            mem_wr_en_d   = 1'b1;
            mem_wr_addr_d = MEM_ADDR_WIDTH'(addr_q >> ADDR_LSB);
            mem_wr_data_d = s_axi.s_axi_wdata;
            mem_wr_strb_d = s_axi.s_axi_wstrb;
          end
          if (s_axi.s_axi_wlast != last_beat) wlast_err_d = 1'b1;
          if (last_beat) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (s_axi.s_axi_bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      id_q          <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      beat_q        <= '0;
      aw_err_q      <= 1'b0;
      wlast_err_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      mem_wr_strb_q <= '0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      size_q        <= size_d;
      burst_q       <= burst_d;
      beat_q        <= beat_d;
      aw_err_q      <= aw_err_d;
      wlast_err_q   <= wlast_err_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_strb_q <= mem_wr_strb_d;
    end
  end

  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_wr_strb = mem_wr_strb_q;
endmodule

// File: tb/tb_axi_wr_responder.sv
// Directed bench for axi_wr_responder: transaction-level model plus literal pins.
module tb_axi_wr_responder;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;
  localparam int IW = 8;
  localparam int MW = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_wr_responder_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();

  logic [MW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [SW-1:0] mem_wr_strb;
  logic          mem_wr_en;

  axi_wr_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW), .MEM_ADDR_WIDTH(MW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_axi       (bus),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_strb (mem_wr_strb),
    .mem_wr_en   (mem_wr_en)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [MW+DW+SW-1:0] exp_q[$];   // {word addr, data, strb}
  logic [IW+1:0]       exp_b_q[$]; // {bid, bresp}
  logic [MW-1:0]       log_q[$];   // observed write addresses of current test
  int                  b_count = 0;
  logic [IW-1:0]       last_bid;
  logic [1:0]          last_bresp;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Compare process: every memory write and every B handshake against the model.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      log_q.push_back(mem_wr_addr);
      if (exp_q.size() == 0) check("unexpected_mem_wr", {mem_wr_addr, mem_wr_data, mem_wr_strb}, 0);
      else check("mem_wr", {mem_wr_addr, mem_wr_data, mem_wr_strb}, exp_q.pop_front());
    end
    if (bus.s_axi_bvalid === 1'b1 && bus.s_axi_bready === 1'b1) begin
      b_count++;
      last_bid   = bus.s_axi_bid;
      last_bresp = bus.s_axi_bresp;
      if (exp_b_q.size() == 0) check("unexpected_b", {bus.s_axi_bid, bus.s_axi_bresp}, 0);
      else check("b_resp", {bus.s_axi_bid, bus.s_axi_bresp}, exp_b_q.pop_front());
    end
  end

  // ---------------- model ----------------
  function automatic logic [MW-1:0] model_word(input int a, input int len, input int size,
                                               input int burst, input int beat);
    int bytes, r, wb, base;
    bytes = 1 << size;
    case (burst)
      0: r = a;
      1: r = (a + beat * bytes) % 65536;
      default: begin
        wb   = (len + 1) * bytes;
        base = (a / wb) * wb;
        r    = base + (a - base + beat * bytes) % wb;
      end
    endcase
    return MW'(r / 4);
  endfunction

  function automatic bit model_err(input int len, input int size, input int burst);
    return (burst == 3) || (size > 2) ||
           (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic logic [DW-1:0] beat_data(input int id, input int a, input int i);
    return {8'(id), 8'h5A, 8'(a), 8'(i)};
  endfunction

  // Push expectations for one transaction; beats are those written before any reset.
  task automatic expect_txn(input int id, input int a, input int len, input int size,
                            input int burst, input logic [SW-1:0] strb, input int wlast_beat,
                            input int beats_written, input bit want_b);
    bit err, wl_err;
    err    = model_err(len, size, burst);
    wl_err = (wlast_beat >= 0) && (wlast_beat != len);
    if (!err)
      for (int i = 0; i < beats_written; i++)
        exp_q.push_back({model_word(a, len, size, burst, i), beat_data(id, a, i), strb});
    if (want_b) exp_b_q.push_back({IW'(id), (err || wl_err) ? 2'b10 : 2'b00});
  endtask

  // ---------------- drivers ----------------
  task automatic set_aw(input int id, input int a, input int len, input int size, input int burst);
    bus.s_axi_awid    = IW'(id);
    bus.s_axi_awaddr  = AW'(a);
    bus.s_axi_awlen   = 8'(len);
    bus.s_axi_awsize  = 3'(size);
    bus.s_axi_awburst = 2'(burst);
    bus.s_axi_awvalid = 1'b1;
  endtask

  task automatic send_aw(input int id, input int a, input int len, input int size, input int burst);
    bit hs;
    int n;
    set_aw(id, a, len, size, burst);
    hs = 0; n = 0;
    while (!hs && n < 100) begin
      @(negedge clk); hs = bus.s_axi_awready;
      @(posedge clk); #1; n++;
    end
    bus.s_axi_awvalid = 1'b0;
    if (!hs) check("aw_timeout", 0, 1);
  endtask

  // Beats first..last-1 of a burst; wlast_beat<0 means wlast on beat len.
  task automatic send_beats(input int id, input int a, input int len, input int first, input int last,
                            input logic [SW-1:0] strb, input int wlast_beat, input int max_gap);
    bit hs;
    int n;
    for (int i = first; i < last; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        bus.s_axi_wvalid = 1'b0;
        @(posedge clk); #1;
      end
      bus.s_axi_wdata  = beat_data(id, a, i);
      bus.s_axi_wstrb  = strb;
      bus.s_axi_wlast  = (wlast_beat < 0) ? (i == len) : (i == wlast_beat);
      bus.s_axi_wvalid = 1'b1;
      hs = 0; n = 0;
      while (!hs && n < 100) begin
        @(negedge clk); hs = bus.s_axi_wready;
        @(posedge clk); #1; n++;
      end
      if (!hs) check("w_timeout", 0, 1);
    end
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_wlast  = 1'b0;
  endtask

  task automatic wait_b();
    bit hs;
    int n;
    bus.s_axi_bready = 1'b1;
    hs = 0; n = 0;
    while (!hs && n < 100) begin
      @(negedge clk); hs = bus.s_axi_bvalid;
      @(posedge clk); #1; n++;
    end
    bus.s_axi_bready = 1'b0;
    if (!hs) check("b_timeout", 0, 1);
  endtask

  task automatic run_txn(input int id, input int a, input int len, input int size, input int burst,
                         input logic [SW-1:0] strb, input int wlast_beat, input int max_gap);
    log_q.delete();
    expect_txn(id, a, len, size, burst, strb, wlast_beat, len + 1, 1'b1);
    send_aw(id, a, len, size, burst);
    send_beats(id, a, len, 0, len + 1, strb, wlast_beat, max_gap);
    wait_b();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, bus.s_axi_awready, 0);
    check({tag, "_wready"}, bus.s_axi_wready, 0);
    check({tag, "_bvalid"}, bus.s_axi_bvalid, 0);
    check({tag, "_bid"}, bus.s_axi_bid, 0);
    check({tag, "_bresp"}, bus.s_axi_bresp, 0);
    check({tag, "_mem_wr_en"}, mem_wr_en, 0);
    check({tag, "_mem_wr_addr"}, mem_wr_addr, 0);
    check({tag, "_mem_wr_data"}, mem_wr_data, 0);
    check({tag, "_mem_wr_strb"}, mem_wr_strb, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0;
    bus.s_axi_awsize = '0; bus.s_axi_awburst = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0;
    bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("idle_awready", bus.s_axi_awready, 1);
    @(posedge clk); #1;

    // INCR size 2 len 3 at 0x10
    run_txn(8'h3C, 16'h0010, 3, 2, 1, 4'hF, -1, 0);
    check("incr_nwr", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("incr_a0", log_q[0], 4); check("incr_a1", log_q[1], 5);
      check("incr_a2", log_q[2], 6); check("incr_a3", log_q[3], 7);
    end
    check("incr_bresp", last_bresp, 0);
    check("incr_bid", last_bid, 8'h3C);

    // WRAP size 2 len 3 at 0x18
    run_txn(8'h11, 16'h0018, 3, 2, 2, 4'hF, -1, 0);
    if (log_q.size() == 4) begin
      check("wrap_a0", log_q[0], 6); check("wrap_a1", log_q[1], 7);
      check("wrap_a2", log_q[2], 4); check("wrap_a3", log_q[3], 5);
    end else check("wrap_nwr", log_q.size(), 4);

    // FIXED len 2 at 0x20, partial strobes
    run_txn(8'h22, 16'h0020, 2, 2, 0, 4'h5, -1, 0);
    check("fixed_nwr", log_q.size(), 3);
    foreach (log_q[i]) check("fixed_addr", log_q[i], 8);

    // Reserved burst type: no writes, SLVERR
    run_txn(8'h33, 16'h0040, 1, 2, 3, 4'hF, -1, 0);
    check("rsvd_nwr", log_q.size(), 0);
    check("rsvd_bresp", last_bresp, 2);

    // Illegal WRAP length and oversize beat: no writes, SLVERR
    run_txn(8'h34, 16'h0040, 2, 2, 2, 4'hF, -1, 0);
    check("wraplen_nwr", log_q.size(), 0);
    run_txn(8'h35, 16'h0040, 0, 3, 1, 4'hF, -1, 0);
    check("size_bresp", last_bresp, 2);

    // Early wlast on beat 1: still four writes, SLVERR
    run_txn(8'h44, 16'h0080, 3, 2, 1, 4'hF, 1, 0);
    check("wlast_nwr", log_q.size(), 4);
    check("wlast_bresp", last_bresp, 2);

    // Random wvalid gaps, size 1 and size 0 INCR
    run_txn(8'h55, 16'h0100, 7, 2, 1, 4'hF, -1, 3);
    check("gap_nwr", log_q.size(), 8);
    run_txn(8'h56, 16'h0202, 5, 1, 1, 4'h3, -1, 2);
    run_txn(8'h57, 16'hFFFD, 4, 0, 1, 4'h1, -1, 1);

    // B backpressure with a second AW pending
    log_q.delete();
    expect_txn(8'h66, 16'h0300, 0, 2, 1, 4'hF, -1, 1, 1'b1);
    expect_txn(8'h77, 16'h0400, 1, 2, 1, 4'hF, -1, 2, 1'b1);
    send_aw(8'h66, 16'h0300, 0, 2, 1);
    send_beats(8'h66, 16'h0300, 0, 0, 1, 4'hF, -1, 0);
    set_aw(8'h77, 16'h0400, 1, 2, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_bvalid", bus.s_axi_bvalid, 1);
      check("stall_bid", bus.s_axi_bid, 8'h66);
      check("stall_bresp", bus.s_axi_bresp, 0);
      check("stall_awready", bus.s_axi_awready, 0);
      @(posedge clk); #1;
    end
    bus.s_axi_bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.s_axi_bready = 1'b0;
    @(negedge clk);
    check("after_b_awready", bus.s_axi_awready, 1);
    @(posedge clk); #1;
    bus.s_axi_awvalid = 1'b0;
    send_beats(8'h77, 16'h0400, 1, 0, 2, 4'hF, -1, 0);
    wait_b();
    check("second_bid", last_bid, 8'h77);

    // Reset on beat 2 of an 8-beat INCR burst
    log_q.delete();
    expect_txn(8'h88, 16'h0500, 7, 2, 1, 4'hF, -1, 2, 1'b0);
    send_aw(8'h88, 16'h0500, 7, 2, 1);
    send_beats(8'h88, 16'h0500, 7, 0, 2, 4'hF, -1, 0);
    bus.s_axi_wdata = beat_data(8'h88, 16'h0500, 2);
    bus.s_axi_wvalid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.s_axi_wvalid = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1; rst = 1'b0;
    bus.s_axi_bready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_b", bus.s_axi_bvalid, 0);
      @(posedge clk); #1;
    end
    bus.s_axi_bready = 1'b0;
    check("midrst_nwr", log_q.size(), 2);
    run_txn(8'h99, 16'h0600, 1, 2, 1, 4'hF, -1, 0);
    check("post_rst_bresp", last_bresp, 0);
    check("post_rst_bid", last_bid, 8'h99);

    // Everything the model expected was seen
    repeat (3) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp_b_q_drained", exp_b_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/axi_wr_responder.md
AXI_WR_RESPONDER -- requirements
Module: axi_wr_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- DATA_WIDTH, 32, W data width; 8, 16, 32, 64 or 128
- ADDR_WIDTH, 16, byte address width
- STRB_WIDTH, DATA_WIDTH/8, strobe width
- ID_WIDTH, 8, AW/B ID width
- MEM_ADDR_WIDTH, ADDR_WIDTH-$clog2(STRB_WIDTH), word address width of the memory port
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clk, in, 1, sole clock
- rst, in, 1, synchronous active-high reset
- s_axi_awid, in, ID_WIDTH, write ID
- s_axi_awaddr, in, ADDR_WIDTH, start byte address
- s_axi_awlen, in, 8, beats-1
- s_axi_awsize, in, 3, log2 bytes per beat
- s_axi_awburst, in, 2, FIXED=0, INCR=1, WRAP=2
- s_axi_awvalid, in, 1 / s_axi_awready, out, 1, AW handshake
- s_axi_wdata, in, DATA_WIDTH / s_axi_wstrb, in, STRB_WIDTH / s_axi_wlast, in, 1, W payload
- s_axi_wvalid, in, 1 / s_axi_wready, out, 1, W handshake
- s_axi_bid, out, ID_WIDTH / s_axi_bresp, out, 2, write response
- s_axi_bvalid, out, 1 / s_axi_bready, in, 1, B handshake
- mem_wr_addr, out, MEM_ADDR_WIDTH, word address
- mem_wr_data, out, DATA_WIDTH / mem_wr_strb, out, STRB_WIDTH, write payload
- mem_wr_en, out, 1, one-cycle write strobe
REQ-003 The block SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have three states: IDLE, BURST, RESP.
REQ-005 IDLE: awready=1, wready=0, bvalid=0. On an AW handshake, latch id, addr, len, size and burst; clear the error flag and beat counter; go to BURST.
REQ-006 At the AW handshake, the error flag SHALL be set to SLVERR (2'b10) if: burst==3, size>$clog2(STRB_WIDTH), or burst==WRAP with len not in {1,3,7,15}.
REQ-007 BURST: wready=1, awready=0. Each W handshake SHALL increment the beat counter. If the error flag is clear, it SHALL also register a memory write.
REQ-008 A registered memory write SHALL drive mem_wr_en=1 for exactly one cycle, on the cycle after the W handshake, with mem_wr_addr=current_addr[ADDR_WIDTH-1:$clog2(STRB_WIDTH)], mem_wr_data=wdata and mem_wr_strb=wstrb. Strobes SHALL pass through unmasked.
REQ-009 After each beat, the address SHALL update as follows: FIXED, unchanged; INCR, +(1<<size) modulo 2^ADDR_WIDTH; WRAP, low bits wrap within the aligned window of (len+1)<<size bytes.
REQ-010 The burst SHALL end on beat len+1 whatever the value of wlast. If wlast differs from (beat==len) on any beat, the error flag SHALL be set to SLVERR, effective for the response only.
REQ-011 On the final beat handshake the FSM SHALL go to RESP.
REQ-012 RESP: bvalid=1, bid=latched id, bresp=error flag (OKAY 2'b00 otherwise). bid and bresp SHALL stay stable until bready. On the B handshake the FSM SHALL go to IDLE, and awready SHALL be 1 on the next cycle.
REQ-013 Only one transaction SHALL be outstanding. Sustained W throughput SHALL be one beat per cycle. Minimum AW-to-B time for a 1-beat burst SHALL be 2 cycles.
REQ-014 An AW presented during BURST or RESP SHALL be held off (awready=0), not dropped. W beats presented in IDLE or RESP SHALL be held off (wready=0).

Reset
REQ-015 With rst high, on the next clk edge: state=IDLE, awready=0 while rst is high, wready=0, bvalid=0, bid=0, bresp=0, mem_wr_en=0, mem_wr_addr/data/strb=0.
REQ-016 Reset mid-burst or mid-response SHALL abandon the transaction with no B response. A write already registered SHALL NOT be re-issued.

Structure
REQ-017 The shared axi_pkg SHALL hold the burst encodings (FIXED/INCR/WRAP), the response encodings (OKAY/EXOKAY/SLVERR/DECERR) and the FSM state enum.
REQ-018 Next-address computation SHALL be one combinational sub-module, axi_burst_addr_next (inputs addr, len, size, burst; output next addr), reusable by a future read responder.

Verification
REQ-019 INCR, size=2, len=3, addr=0x0010, strb=0xF: mem_wr_addr 4,5,6,7, one mem_wr_en per beat, bresp=0, bid=awid.
REQ-020 WRAP, size=2, len=3, addr=0x0018: mem_wr_addr 6,7,4,5.
REQ-021 FIXED, len=2, addr=0x0020: three writes to word 8. Also awburst=3, len=1: no mem_wr_en, bresp=2'b10.
REQ-022 INCR len=3 with wlast asserted on beat 1: four writes occur, burst ends after beat 3, bresp=2'b10. Also wvalid toggled randomly: every beat written exactly once, in order.
REQ-023 bready held low 10 cycles while a second AW is pending: bvalid and bid stay stable, awready=0 throughout. Second AW accepted the cycle after the B handshake.
REQ-024 rst asserted on beat 2 of a len=7 INCR burst: no bvalid, all outputs at reset values. A new transaction afterwards completes with bresp=0.
